// File: rtl/fa_pkg.sv
// Shared types for the ripple-carry full adder: per-bit half-adder wiring
// and the legal width range.
package fa_pkg;

  localparam int FA_MIN_WIDTH = 1;
  localparam int FA_MAX_WIDTH = 64;

  // Per-bit intermediates: first half adder yields propagate/generate,
  // second yields the sum bit and the carry generated by the incoming carry.
  typedef struct packed {
    logic p;
    logic g;
    logic s;
    logic g2;
  } fa_bit_t;

  function automatic logic carry_merge(input fa_bit_t bw);
    return bw.g | bw.g2;
  endfunction

endpackage

// File: rtl/fa_ha.sv
// Half adder leaf: s = a ^ b, c = a & b. Purely combinational.
module ha (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

// File: rtl/fa.sv
// WIDTH-bit ripple-carry adder built from two half adders per bit, with an
// optional output register (REG_OUT=1: latency 1, async active-low clear).
module fa
  import fa_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_bit_t bw;

    ha u_ha_ab (
      .a_i (a[i]),
      .b_i (b[i]),
      .s_o (bw.p),
      .c_o (bw.g)
    );

    ha u_ha_pc (
      .a_i (bw.p),
      .b_i (c[i]),
      .s_o (bw.s),
      .c_o (bw.g2)
    );

    assign sum_d[i] = bw.s;
    assign c[i+1]   = carry_merge(bw);
  end

  assign cout_d = c[WIDTH];

  if (REG_OUT != 0) begin : g_reg
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    // No enable: captures every edge; reset clears without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q  <= '0;
        cout_q <= 1'b0;
      end else begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign sum  = sum_d;
    assign cout = cout_d;
  end

endmodule

// File: tb/tb_fa.sv
// Bench for fa: exhaustive 1-bit, registered latency, async reset, ripple
// boundaries and random vectors against an arithmetic reference.
module tb_fa;

  logic clk;
  logic rst_n;

  logic        a1c, b1c, cin1c;
  logic        s1c, co1c;
  logic        a1r, b1r, cin1r;
  logic        s1r, co1r;
  logic [7:0]  a8, b8;
  logic        cin8;
  logic [7:0]  s8c, s8r;
  logic        co8c, co8r;
  logic [63:0] a64, b64;
  logic        cin64;
  logic [63:0] s64;
  logic        co64;

  int checks;
  int failures;

  fa #(.WIDTH(1), .REG_OUT(0)) u_c1 (
    .clk(clk), .rst_n(rst_n), .a(a1c), .b(b1c), .cin(cin1c), .sum(s1c), .cout(co1c));
  fa #(.WIDTH(1), .REG_OUT(1)) u_r1 (
    .clk(clk), .rst_n(rst_n), .a(a1r), .b(b1r), .cin(cin1r), .sum(s1r), .cout(co1r));
  fa #(.WIDTH(8), .REG_OUT(0)) u_c8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .sum(s8c), .cout(co8c));
  fa #(.WIDTH(8), .REG_OUT(1)) u_r8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .sum(s8r), .cout(co8r));
  fa #(.WIDTH(64), .REG_OUT(0)) u_c64 (
    .clk(clk), .rst_n(rst_n), .a(a64), .b(b64), .cin(cin64), .sum(s64), .cout(co64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic ci);
    return {1'b0, x} + {1'b0, y} + {8'b0, ci};
  endfunction

  function automatic logic [64:0] ref64(input logic [63:0] x, input logic [63:0] y, input logic ci);
    return {1'b0, x} + {1'b0, y} + {64'b0, ci};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    a1c = 0; b1c = 0; cin1c = 0;
    a1r = 1; b1r = 1; cin1r = 1;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1;
    a64 = '0; b64 = '0; cin64 = 0;
    #1;
    checks++;
    if ({co1r, s1r} !== 2'b00) begin
      failures++;
      $display("FAIL reset_r1 got=%b want=00", {co1r, s1r});
    end
    @(posedge clk); #1;
    checks++;
    if ({co8r, s8r} !== 9'h000) begin
      failures++;
      $display("FAIL reset_r8_held got=%h want=000", {co8r, s8r});
    end
    @(negedge clk);
    a1r = 0; b1r = 0; cin1r = 0;
    rst_n = 1'b1;
    #1;
    checks++;
    if ({co8r, s8r} !== 9'h000) begin
      failures++;
      $display("FAIL reset_release_no_edge got=%h want=000", {co8r, s8r});
    end
  endtask

  task automatic test_exhaustive_1bit();
    logic [1:0] want [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    for (int v = 0; v < 8; v++) begin
      {a1c, b1c, cin1c} = v[2:0];
      #5;
      checks++;
      if ({co1c, s1c} !== want[v]) begin
        failures++;
        $display("FAIL exhaustive_1bit v=%0d got=%b want=%b", v, {co1c, s1c}, want[v]);
      end
      #5;
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    a1r = 0; b1r = 0; cin1r = 0;
    @(posedge clk); @(negedge clk);
    a1r = 1; b1r = 1; cin1r = 1;
    #1;
    checks++;
    if ({co1r, s1r} !== 2'b00) begin
      failures++;
      $display("FAIL registered_early got=%b want=00", {co1r, s1r});
    end
    @(posedge clk); #1;
    checks++;
    if ({co1r, s1r} !== 2'b11) begin
      failures++;
      $display("FAIL registered_latency got=%b want=11", {co1r, s1r});
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({co1r, s1r} !== 2'b00) begin
      failures++;
      $display("FAIL async_reset_immediate got=%b want=00", {co1r, s1r});
    end
    @(posedge clk); #1;
    checks++;
    if ({co1r, s1r} !== 2'b00) begin
      failures++;
      $display("FAIL async_reset_hold got=%b want=00", {co1r, s1r});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({co1r, s1r} !== 2'b00) begin
      failures++;
      $display("FAIL async_reset_release_early got=%b want=00", {co1r, s1r});
    end
    @(posedge clk); #1;
    checks++;
    if ({co1r, s1r} !== 2'b11) begin
      failures++;
      $display("FAIL async_reset_recover got=%b want=11", {co1r, s1r});
    end
  endtask

  task automatic test_boundaries();
    logic [7:0] va [3] = '{8'hFF, 8'hFF, 8'h00};
    logic [7:0] vb [3] = '{8'h00, 8'hFF, 8'h00};
    logic       vc [3] = '{1'b1, 1'b1, 1'b0};
    logic [8:0] vw [3] = '{9'h100, 9'h1FF, 9'h000};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a8 = va[k]; b8 = vb[k]; cin8 = vc[k];
      #1;
      checks++;
      if ({co8c, s8c} !== vw[k]) begin
        failures++;
        $display("FAIL boundary_comb k=%0d got=%h want=%h", k, {co8c, s8c}, vw[k]);
      end
      @(posedge clk); #1;
      checks++;
      if ({co8r, s8r} !== vw[k]) begin
        failures++;
        $display("FAIL boundary_reg k=%0d got=%h want=%h", k, {co8r, s8r}, vw[k]);
      end
    end
    a64 = '1; b64 = '0; cin64 = 1'b1;
    #1;
    checks++;
    if ({co64, s64} !== {1'b1, 64'h0}) begin
      failures++;
      $display("FAIL ripple64 got=%h want=%h", {co64, s64}, {1'b1, 64'h0});
    end
    a64 = '1; b64 = '1; cin64 = 1'b1;
    #1;
    checks++;
    if ({co64, s64} !== {1'b1, {64{1'b1}}}) begin
      failures++;
      $display("FAIL max64 got=%h want=%h", {co64, s64}, {1'b1, {64{1'b1}}});
    end
  endtask

  task automatic test_random();
    logic [8:0]  exp8;
    logic [8:0]  prev8;
    logic [64:0] exp64;
    prev8 = ref8(a8, b8, cin8);
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      cin8 = 1'($urandom);
      a64  = {$urandom, $urandom};
      b64  = {$urandom, $urandom};
      cin64 = 1'($urandom);
      exp8  = ref8(a8, b8, cin8);
      exp64 = ref64(a64, b64, cin64);
      #1;
      checks++;
      if ({co8c, s8c} !== exp8) begin
        failures++;
        $display("FAIL random_comb8 n=%0d a=%h b=%h cin=%b got=%h want=%h", n, a8, b8, cin8, {co8c, s8c}, exp8);
      end
      checks++;
      if ({co8r, s8r} !== prev8) begin
        failures++;
        $display("FAIL random_reg8_early n=%0d got=%h want=%h", n, {co8r, s8r}, prev8);
      end
      checks++;
      if ({co64, s64} !== exp64) begin
        failures++;
        $display("FAIL random_comb64 n=%0d got=%h want=%h", n, {co64, s64}, exp64);
      end
      @(posedge clk); #1;
      checks++;
      if ({co8r, s8r} !== exp8) begin
        failures++;
        $display("FAIL random_reg8 n=%0d a=%h b=%h cin=%b got=%h want=%h", n, a8, b8, cin8, {co8r, s8r}, exp8);
      end
      prev8 = exp8;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_exhaustive_1bit();
    test_registered();
    test_async_reset();
    test_boundaries();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
